// File: rtl/rf_pkg.sv
// Shared constants and FSM encoding for the register-file write controller.
package rf_pkg;
  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int DEPTH = 2 ** AW;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } rf_state_e;

  localparam logic [AW-1:0] REG_ZERO = '0;
endpackage

// File: rtl/rf_prio_arb.sv
// Fixed-priority one-hot picker: the lowest set request bit wins.
module rf_prio_arb #(
  parameter int N = 3
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);
  // Isolate the lowest set bit (two's-complement trick).
  assign gnt = req & (~req + N'(1));
endmodule

// File: rtl/rf_write_ctrl.sv
// Register-file write-port controller: post-reset clear of every register,
// then starvation-protected fixed-priority sharing among NREQ writeback sources.
module rf_write_ctrl #(
  parameter int NREQ       = 3,
  parameter int AW         = rf_pkg::AW,
  parameter int DW         = rf_pkg::DW,
  parameter int STARVE_MAX = 4,
  parameter int DEPTH      = rf_pkg::DEPTH
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 busy,
  output logic                 RFWE,
  output logic [AW-1:0]        RFWA,
  output logic [DW-1:0]        RFWD
);
  import rf_pkg::*;

  localparam int CW = 4;

  rf_state_e                 state_q, state_d;
  logic [AW-1:0]             clr_cnt_q, clr_cnt_d;
  logic [NREQ-1:0][CW-1:0]   wait_q, wait_d;
  logic [NREQ-1:0]           starved, gnt_starve, gnt_all, gnt;
  logic [AW-1:0]             g_addr;
  logic [DW-1:0]             g_data;

  always_comb begin
    starved = '0;
    for (int i = 0; i < NREQ; i++)
      starved[i] = req_valid[i] && (wait_q[i] == CW'(STARVE_MAX));
  end

  rf_prio_arb #(.N(NREQ)) u_arb_starve (.req(starved),   .gnt(gnt_starve));
  rf_prio_arb #(.N(NREQ)) u_arb_all    (.req(req_valid), .gnt(gnt_all));

  always_comb begin
    gnt = '0;
    if (!RST && state_q == ST_RUN)
      gnt = (|starved) ? gnt_starve : gnt_all;
    g_addr = '0;
    g_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        g_addr = req_addr[i*AW +: AW];
        g_data = req_data[i*DW +: DW];
      end
    end
  end

  // Outputs are gated by RST directly so they go quiet the moment reset rises.
  always_comb begin
    req_ready = gnt;
    busy      = RST || (state_q == ST_CLEAR);
    RFWE      = 1'b0;
    RFWA      = '0;
    RFWD      = '0;
    if (!RST) begin
      if (state_q == ST_CLEAR) begin
        RFWE = 1'b1;
        RFWA = clr_cnt_q;
      end else begin
        RFWE = (|gnt) && (g_addr != AW'(REG_ZERO));
        RFWA = g_addr;
        RFWD = g_data;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == ST_CLEAR) begin
      clr_cnt_d = clr_cnt_q + AW'(1);
      if (clr_cnt_q == AW'(DEPTH - 1))
        state_d = ST_RUN;
    end
  end

  // Wait counters saturate at STARVE_MAX; any grant or withdrawn request resets them.
  always_comb begin
    wait_d = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i] && !gnt[i])
        wait_d[i] = (wait_q[i] == CW'(STARVE_MAX)) ? wait_q[i] : wait_q[i] + CW'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
      wait_q    <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      wait_q    <= wait_d;
    end
  end
endmodule

// File: tb/tb_rf_write_ctrl.sv
// Bench for rf_write_ctrl: vector table, corner-case sequences and random
// traffic checked against a cycle-level behavioural model and shadow register file.
module tb_rf_write_ctrl;
  localparam int NREQ = 3, AW = 5, DW = 32, SM = 4, DEPTH = 32;

  logic                 CLK = 1'b0;
  logic                 RST = 1'b1;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ*AW-1:0]   req_addr  = '0;
  logic [NREQ*DW-1:0]   req_data  = '0;
  logic [NREQ-1:0]      req_ready;
  logic                 busy, RFWE;
  logic [AW-1:0]        RFWA;
  logic [DW-1:0]        RFWD;

  rf_write_ctrl #(.NREQ(NREQ), .AW(AW), .DW(DW), .STARVE_MAX(SM), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready), .busy(busy), .RFWE(RFWE), .RFWA(RFWA), .RFWD(RFWD)
  );

  always #5 CLK = ~CLK;

  // Downstream register file fed by the DUT's write port.
  logic [DW-1:0] rf_mem [DEPTH];
  always @(posedge CLK) if (RFWE) rf_mem[RFWA] <= RFWD;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Behavioural model: edges since reset release, per-requester refusal counts.
  int            since = 0;
  int            wc [NREQ];
  logic [DW-1:0] exp_mem [DEPTH];
  logic [NREQ-1:0] e_ready;
  logic          e_we, e_busy;
  logic [AW-1:0] e_wa;
  logic [DW-1:0] e_wd;

  task automatic model_eval();
    int g;
    e_ready = '0; e_we = 0; e_wa = '0; e_wd = '0; e_busy = 1;
    g = -1;
    if (RST) return;
    if (since < DEPTH) begin
      e_we = 1; e_wa = AW'(since);
      return;
    end
    e_busy = 0;
    for (int i = 0; i < NREQ; i++) if (g < 0 && req_valid[i] && wc[i] == SM) g = i;
    for (int i = 0; i < NREQ; i++) if (g < 0 && req_valid[i]) g = i;
    if (g >= 0) begin
      e_ready[g] = 1'b1;
      e_wa = req_addr[g*AW +: AW];
      e_wd = req_data[g*DW +: DW];
      e_we = (e_wa != 0);
    end
  endtask

  task automatic model_update();
    if (RST) begin
      since = 0;
      for (int i = 0; i < NREQ; i++) wc[i] = 0;
      return;
    end
    if (e_we) exp_mem[e_wa] = e_wd;
    if (since < DEPTH) since++;
    for (int i = 0; i < NREQ; i++)
      wc[i] = (req_valid[i] && !e_ready[i]) ? ((wc[i] < SM) ? wc[i] + 1 : SM) : 0;
  endtask

  // One clock: settle, compare all outputs with the model, take the edge.
  task automatic cycle();
    #1;
    model_eval();
    chk("ready", req_ready, e_ready);
    chk("busy",  busy,      e_busy);
    chk("we",    RFWE,      e_we);
    chk("wa",    RFWA,      e_wa);
    chk("wd",    RFWD,      e_wd);
    @(posedge CLK);
    model_update();
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i] = v;
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  typedef struct {
    logic [NREQ-1:0]    v;
    logic [NREQ*AW-1:0] a;
    logic [NREQ*DW-1:0] d;
    logic [NREQ-1:0]    rdy;
    logic               we;
    logic [AW-1:0]      wa;
    logic [DW-1:0]      wd;
  } vec_t;

  vec_t tbl [5];

  initial begin
    for (int i = 0; i < NREQ; i++) wc[i] = 0;
    tbl[0] = '{3'b111, {5'd7, 5'd6, 5'd5}, {32'hCCCC0003, 32'hBBBB0002, 32'hAAAA0001}, 3'b001, 1'b1, 5'd5, 32'hAAAA0001};
    tbl[1] = '{3'b110, {5'd7, 5'd6, 5'd5}, {32'hCCCC0003, 32'hBBBB0002, 32'hAAAA0001}, 3'b010, 1'b1, 5'd6, 32'hBBBB0002};
    tbl[2] = '{3'b100, {5'd7, 5'd6, 5'd5}, {32'hCCCC0003, 32'hBBBB0002, 32'hAAAA0001}, 3'b100, 1'b1, 5'd7, 32'hCCCC0003};
    tbl[3] = '{3'b010, {5'd7, 5'd0, 5'd5}, {32'hCCCC0003, 32'hDEADBEEF, 32'hAAAA0001}, 3'b010, 1'b0, 5'd0, 32'hDEADBEEF};
    tbl[4] = '{3'b000, {5'd0, 5'd0, 5'd0}, {32'h0, 32'h0, 32'h0},                      3'b000, 1'b0, 5'd0, 32'h0};

    // Reset, then the full clear sequence and an idle RUN cycle.
    cycle(); cycle();
    RST = 1'b0;
    repeat (DEPTH) cycle();
    cycle();

    // Priority and register-0 vectors.
    foreach (tbl[k]) begin
      req_valid = tbl[k].v; req_addr = tbl[k].a; req_data = tbl[k].d;
      #1;
      chk($sformatf("tbl%0d_ready", k), req_ready, tbl[k].rdy);
      chk($sformatf("tbl%0d_we", k),    RFWE,      tbl[k].we);
      chk($sformatf("tbl%0d_wa", k),    RFWA,      tbl[k].wa);
      chk($sformatf("tbl%0d_wd", k),    RFWD,      tbl[k].wd);
      cycle();
    end
    chk("r0_zero", rf_mem[0], 32'h0);
    chk("r5", rf_mem[5], 32'hAAAA0001);
    chk("r6", rf_mem[6], 32'hBBBB0002);
    chk("r7", rf_mem[7], 32'hCCCC0003);

    // Starvation: requester 0 always busy, requester 2 promoted in cycle 4.
    set_req(0, 1'b1, 5'd1, $urandom);
    set_req(2, 1'b1, 5'd3, 32'h5EED0002);
    for (int c = 0; c < 6; c++) begin
      #1;
      chk($sformatf("starve_c%0d", c), req_ready, (c == 4) ? 3'b100 : 3'b001);
      cycle();
      if (e_ready[0]) req_data[0 +: DW] = $urandom;
      if (e_ready[2]) set_req(2, 1'b0, 5'd0, 32'h0);
    end
    set_req(0, 1'b0, 5'd0, 32'h0);
    cycle();

    // Reset in RUN with requests pending; all must wait for the full clear.
    set_req(0, 1'b1, 5'd8,  32'h11110008);
    set_req(1, 1'b1, 5'd9,  32'h22220009);
    set_req(2, 1'b1, 5'd10, 32'h3333000A);
    cycle();
    RST = 1'b1;
    #1;
    chk("rstrun_ready", req_ready, 3'b000);
    chk("rstrun_we", RFWE, 1'b0);
    chk("rstrun_busy", busy, 1'b1);
    cycle();
    RST = 1'b0;
    repeat (DEPTH) cycle();
    #1;
    chk("rstrun_first_grant", req_ready, 3'b001);
    repeat (4) begin
      cycle();
      for (int i = 0; i < NREQ; i++) if (e_ready[i]) req_valid[i] = 1'b0;
    end

    // Reset mid-clear at clr_cnt = 17 restarts from register 0.
    RST = 1'b1;
    cycle();
    RST = 1'b0;
    repeat (17) cycle();
    #1;
    chk("midclr_wa17", RFWA, 5'd17);
    RST = 1'b1;
    cycle();
    RST = 1'b0;
    #1;
    chk("midclr_restart_wa", RFWA, 5'd0);
    chk("midclr_restart_we", RFWE, 1'b1);
    repeat (DEPTH) cycle();
    #1;
    chk("midclr_done_busy", busy, 1'b0);

    // Random traffic honouring the hold-until-ready obligation.
    for (int c = 0; c < 400; c++) begin
      cycle();
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] || e_ready[i]) begin
          if ($urandom_range(0, 3) != 0)
            set_req(i, 1'b1, AW'($urandom_range(0, DEPTH - 1)), $urandom);
          else
            set_req(i, 1'b0, 5'd0, 32'h0);
        end
      end
    end
    set_req(0, 1'b0, 5'd0, 32'h0);
    set_req(1, 1'b0, 5'd0, 32'h0);
    set_req(2, 1'b0, 5'd0, 32'h0);
    cycle();

    for (int k = 0; k < DEPTH; k++)
      chk($sformatf("mem%0d", k), rf_mem[k], exp_mem[k]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
